text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
- Write-side controller for the character RAM that feeds the font/VGA text pipeline.
- Accepts a byte stream over a valid/ready handshake and interprets it as a simple terminal.
- Printable characters are written at the cursor position; control codes move the cursor or clear cells.
- Drives the RAM write port (wclk = px_clk); the read side stays owned by the display pipeline.

Parameters:
- COLS, 20, characters per row (640 / (8*2^Zoom) with Zoom=2)
- ROWS, 4, text rows held in RAM; legal only if COLS*ROWS <= 2^ADDR_WIDTH
- ADDR_WIDTH, 7, RAM address width
- BLANK, 8'h20, fill code used for clears

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_data  in  8  character/control byte
- in_valid  in  1  in_data valid
- in_ready  out  1  controller can accept a byte this cycle
- waddr  out  ADDR_WIDTH  RAM write address
- wdata  out  8  RAM write data
- write_en  out  1  RAM write strobe, one cell per cycle
- cur_col  out  $clog2(COLS)  cursor column
- cur_row  out  $clog2(ROWS)  cursor row
- busy  out  1  high in CLR_SCREEN or CLR_LINE

Behaviour:
- Reset values (resetn low, asynchronous): write_en=0, waddr=0, wdata=0, in_ready=0, cur_col=0, cur_row=0, busy=1, state=CLR_SCREEN, clear counter=0.
- Reset asserted mid-operation aborts immediately; no partial state survives.
- Address arithmetic: waddr = cur_row*COLS + cur_col, computed at ADDR_WIDTH. No write may ever exceed COLS*ROWS-1.
- Outputs are registered. A write resulting from acceptance at edge N shows write_en=1 with its waddr/wdata during cycle N..N+1, i.e. 1-cycle latency.
- in_ready = (state==IDLE). A byte transfers on an edge with in_valid && in_ready. Back-to-back transfers are allowed in IDLE.

States:
- CLR_SCREEN: write BLANK to addresses 0..COLS*ROWS-1, one per cycle, in ascending order. Then cursor=(0,0) and go to IDLE. Entered after reset and on FF.
- CLR_LINE: write BLANK to cur_row*COLS+0..COLS-1 in ascending order, then go to IDLE. Cursor column stays 0 throughout.
- IDLE: decode each accepted byte as follows.
  - 0x20..0x7E: write the byte at the cursor, then advance the column. If cur_col==COLS-1, perform a line advance instead.
  - 0x0A (LF): line advance.
  - 0x0D (CR): cur_col=0; no write.
  - 0x08 (BS): cur_col-1 if cur_col>0, else no change; no write.
  - 0x0C (FF): go to CLR_SCREEN.
  - All other bytes: accepted and discarded, no effect.
- Line advance: cur_col=0. cur_row+1, wrapping from ROWS-1 to 0 (no scrolling). Then go to CLR_LINE for the new row.
- Printable at the last column: the character write and CLR_LINE entry happen on the same acceptance. The character write issues first, then the COLS clear writes on the following cycles.
- write_en is low in IDLE whenever no printable byte was accepted on the previous edge.
- in_valid held while busy: the byte is not consumed; upstream holds data stable.

Test Plan:
- Release resetn -> exactly 80 writes of 0x20 to waddr 0..79 on consecutive cycles, busy=1 throughout. Then in_ready=1, cursor=(0,0), write_en=0.
- After init, send 'A' (0x41) and 'B' (0x42) back-to-back -> writes (0,0x41) then (1,0x42) on consecutive cycles, cur_col=2, in_ready never drops.
- Send 20 printable bytes from (0,0) -> 20th written at addr 19. Then 20 BLANK writes to addrs 20..39, cursor=(1,0), in_ready low for 20 cycles. The 21st byte lands at addr 20.
- Cursor at row 3 col 5, send LF -> BLANK to addrs 0..19, cursor=(0,0). Send CR at col 7 -> col 0, no write. Send BS at col 0 -> no change. Send 0x01 -> accepted, no effect.
- At cursor (2,4), send FF -> 80 BLANK writes to 0..79, cursor=(0,0).
- Pulse resetn low during CLR_LINE -> outputs return to reset values asynchronously. A full 80-cell clear restarts from address 0 after release.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Write-side terminal controller for the text-mode character RAM.
// Turns a byte stream into cell writes, cursor moves and screen/line clears.
module text_console_ctrl #(
    parameter int unsigned COLS       = 20,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic                      px_clk,
    input  logic                      resetn,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [7:0]                wdata,
    output logic                      write_en,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic                      busy
);

    localparam int unsigned ColW = $clog2(COLS);
    localparam int unsigned RowW = $clog2(ROWS);

    localparam logic [ADDR_WIDTH-1:0] LastCell    = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] LastLineOfs = ADDR_WIDTH'(COLS - 1);
    localparam logic [ColW-1:0]       LastCol     = ColW'(COLS - 1);
    localparam logic [RowW-1:0]       LastRow     = RowW'(ROWS - 1);

    typedef enum logic [1:0] {StClrScreen, StClrLine, StIdle} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] cell_addr;
    logic [RowW-1:0]       next_row;
    logic                  accept;
    logic                  printable;

    assign row_base  = ADDR_WIDTH'(cur_row) * ADDR_WIDTH'(COLS);
    assign cell_addr = row_base + ADDR_WIDTH'(cur_col);
    assign next_row  = (cur_row == LastRow) ? '0 : cur_row + RowW'(1);
    assign in_ready  = (state_q == StIdle);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StClrScreen;
            clr_cnt_q <= '0;
            write_en  <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
        end else begin
            write_en <= 1'b0;
            case (state_q)
                StClrScreen: begin
                    write_en <= 1'b1;
                    waddr    <= clr_cnt_q;
                    wdata    <= BLANK;
                    if (clr_cnt_q == LastCell) begin
                        clr_cnt_q <= '0;
                        cur_col   <= '0;
                        cur_row   <= '0;
                        state_q   <= StIdle;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                StClrLine: begin
                    write_en <= 1'b1;
                    waddr    <= row_base + clr_cnt_q;
                    wdata    <= BLANK;
                    if (clr_cnt_q == LastLineOfs) begin
                        clr_cnt_q <= '0;
                        state_q   <= StIdle;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                StIdle: begin
                    if (accept) begin
                        if (printable) begin
                            write_en <= 1'b1;
                            waddr    <= cell_addr;
                            wdata    <= in_data;
                            // Writing the last column wraps straight into a line advance.
                            if (cur_col == LastCol) begin
                                cur_col <= '0;
                                cur_row <= next_row;
                                state_q <= StClrLine;
                            end else begin
                                cur_col <= cur_col + ColW'(1);
                            end
                        end else begin
                            case (in_data)
                                8'h0A: begin
                                    cur_col <= '0;
                                    cur_row <= next_row;
                                    state_q <= StClrLine;
                                end
                                8'h0D: cur_col <= '0;
                                8'h08: begin
                                    if (cur_col != '0) begin
                                        cur_col <= cur_col - ColW'(1);
                                    end
                                end
                                8'h0C: state_q <= StClrScreen;
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_q <= StClrScreen;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: stimulus queues expected RAM writes,
// a negedge monitor pops and compares every write the controller issues.
module tb_text_console_ctrl;

    localparam int COLS = 20;
    localparam int ROWS = 4;
    localparam int AW   = 7;

    logic          px_clk   = 1'b0;
    logic          resetn   = 1'b1;
    logic [7:0]    in_data  = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          write_en;
    logic [4:0]    cur_col;
    logic [1:0]    cur_row;
    logic          busy;

    text_console_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (AW),
        .BLANK      (8'h20)
    ) dut (
        .px_clk   (px_clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .waddr    (waddr),
        .wdata    (wdata),
        .write_en (write_en),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 px_clk = ~px_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  w;
    int  cyc;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge px_clk) begin
        if (resetn && write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr %0d data %02h required none",
                         waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (waddr !== mon_e.addr || wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_content got addr %0d data %02h required addr %0d data %02h",
                             waddr, wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        exp_q.push_back('{addr: AW'(addr), data: data});
    endtask

    task automatic push_blank(input int base, input int n);
        for (int i = 0; i < n; i++) push_wr(base + i, 8'h20);
    endtask

    // Offer one byte; returns the number of cycles spent waiting for in_ready.
    task automatic send(input logic [7:0] b, output int waited);
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 500) begin
            @(posedge px_clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready 0 required 1 for byte %02h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge px_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_print(input int base, input int n, input logic [7:0] first);
        int wt;
        for (int i = 0; i < n; i++) begin
            push_wr(base + i, first + 8'(i));
            send(first + 8'(i), wt);
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!in_ready && cycles < 1000) begin
            @(posedge px_clk);
            #1;
            cycles++;
        end
    endtask

    task automatic settle(input string name);
        @(posedge px_clk);
        #1;
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string name, input int row, input int col);
        check({name, "_row"}, int'(cur_row), row);
        check({name, "_col"}, int'(cur_col), col);
    endtask

    task automatic check_reset(input string name);
        check({name, "_write_en"}, int'(write_en), 0);
        check({name, "_waddr"}, int'(waddr), 0);
        check({name, "_wdata"}, int'(wdata), 0);
        check({name, "_in_ready"}, int'(in_ready), 0);
        check({name, "_busy"}, int'(busy), 1);
        check_cursor(name, 0, 0);
    endtask

    task automatic init_clear(input string name);
        int c;
        push_blank(0, COLS * ROWS);
        wait_idle(c);
        check({name, "_clear_cycles"}, c, COLS * ROWS);
        settle(name);
        check({name, "_write_en_idle"}, int'(write_en), 0);
        check({name, "_in_ready"}, int'(in_ready), 1);
        check({name, "_busy"}, int'(busy), 0);
        check_cursor(name, 0, 0);
    endtask

    initial begin
        #2 resetn = 1'b0;
        #1 check_reset("reset");
        repeat (3) @(posedge px_clk);
        #1;
        check("reset_busy_held", int'(busy), 1);
        resetn = 1'b1;
        init_clear("init");

        // Back-to-back printables.
        push_wr(0, 8'h41);
        send(8'h41, w);
        check("ab_wait_a", w, 0);
        push_wr(1, 8'h42);
        send(8'h42, w);
        check("ab_wait_b", w, 0);
        settle("ab");
        check("ab_write_en_idle", int'(write_en), 0);
        check_cursor("ab", 0, 2);

        // Full row wraps into a line clear of row 1.
        send(8'h0D, w);
        settle("cr_home");
        check_cursor("cr_home", 0, 0);
        send_print(0, COLS, 8'h61);
        push_blank(COLS, COLS);
        check("wrap_ready_low", int'(in_ready), 0);
        wait_idle(cyc);
        check("wrap_clear_cycles", cyc, COLS);
        check_cursor("wrap", 1, 0);
        send_print(COLS, 1, 8'h5A);
        settle("wrap_next");
        check_cursor("wrap_next", 1, 1);

        // Walk to row 3 col 5, then LF wraps the row to 0.
        push_blank(2 * COLS, COLS);
        send(8'h0A, w);
        wait_idle(cyc);
        check("lf_row2_cycles", cyc, COLS);
        push_blank(3 * COLS, COLS);
        send(8'h0A, w);
        wait_idle(cyc);
        send_print(3 * COLS, 5, 8'h30);
        settle("row3");
        check_cursor("row3", 3, 5);
        push_blank(0, COLS);
        send(8'h0A, w);
        wait_idle(cyc);
        check("lf_wrap_cycles", cyc, COLS);
        settle("lf_wrap");
        check_cursor("lf_wrap", 0, 0);

        // CR / BS / discarded codes.
        send_print(0, 7, 8'h61);
        settle("col7");
        check_cursor("col7", 0, 7);
        send(8'h0D, w);
        settle("cr");
        check_cursor("cr", 0, 0);
        send(8'h08, w);
        settle("bs_col0");
        check_cursor("bs_col0", 0, 0);
        send_print(0, 1, 8'h7E);
        settle("tilde");
        check_cursor("tilde", 0, 1);
        send(8'h08, w);
        settle("bs_col1");
        check_cursor("bs_col1", 0, 0);
        send(8'h01, w);
        check("ctl01_wait", w, 0);
        check("ctl01_ready", int'(in_ready), 1);
        settle("ctl01");
        check_cursor("ctl01", 0, 0);
        send(8'h7F, w);
        settle("del");
        check_cursor("del", 0, 0);

        // FF from (2,4).
        push_blank(COLS, COLS);
        send(8'h0A, w);
        wait_idle(cyc);
        push_blank(2 * COLS, COLS);
        send(8'h0A, w);
        wait_idle(cyc);
        send_print(2 * COLS, 4, 8'h6B);
        settle("pre_ff");
        check_cursor("pre_ff", 2, 4);
        push_blank(0, COLS * ROWS);
        send(8'h0C, w);
        wait_idle(cyc);
        check("ff_clear_cycles", cyc, COLS * ROWS);
        settle("ff");
        check_cursor("ff", 0, 0);

        // Reset in the middle of a line clear.
        push_blank(COLS, 4);
        send(8'h0A, w);
        repeat (5) begin
            @(posedge px_clk);
            #1;
        end
        check("midclr_busy", int'(busy), 1);
        resetn = 1'b0;
        #1;
        check_reset("midclr_reset");
        check("midclr_drain", exp_q.size(), 0);
        repeat (2) @(posedge px_clk);
        #1;
        resetn = 1'b1;
        init_clear("reinit");

        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
